// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: tracks SYNC/PID/payload/EOP framing, streams
// payload bytes to the receive FIFO and flags framing errors.
`timescale 1ns/1ps

module usb_rx_pkt_ctrl #(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned BUF_DEPTH      = 64,
  parameter int unsigned OCC_W          = 7,
  parameter int unsigned PID_CHECK      = 1
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 d_edge,
  input  logic                                 eop,
  input  logic                                 byte_received,
  input  logic [7:0]                           rcv_data,
  input  logic [OCC_W-1:0]                     buffer_occupancy,
  output logic                                 rx_transfer_active,
  output logic                                 rx_error,
  output logic [3:0]                           rx_packet,
  output logic                                 rx_data_ready,
  output logic [7:0]                           rx_packet_data,
  output logic                                 store_rx_packet_data,
  output logic                                 flush,
  output logic [$clog2(MAX_DATA_BYTES+3)-1:0]  rx_byte_count
);

  localparam int unsigned      CNT_W      = $clog2(MAX_DATA_BYTES + 3);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(MAX_DATA_BYTES + 3);
  localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(BUF_DEPTH);
  localparam logic [7:0]       SYNC_BYTE  = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    PID    = 3'd2,
    TOKEN  = 3'd3,
    DATA   = 3'd4,
    HSHAKE = 3'd5,
    ERR    = 3'd6,
    DONE   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PK_BAD    = 2'd0,
    PK_TOKEN  = 2'd1,
    PK_DATA   = 2'd2,
    PK_HSHAKE = 2'd3
  } pid_kind_t;

  state_t           state, state_nxt;
  pid_kind_t        pid_kind;
  logic             error_nxt;
  logic [3:0]       packet_nxt;
  logic [7:0]       data_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             store_nxt;
  logic             flush_nxt;
  logic             ready_nxt;
  logic             active_nxt;

  // PID class from the lower nibble, optionally gated by the complement check
  always_comb begin
    pid_kind = PK_BAD;
    case (rcv_data[3:0])
      PID_OUT, PID_IN:             pid_kind = PK_TOKEN;
      PID_DATA0, PID_DATA1:        pid_kind = PK_DATA;
      PID_ACK, PID_NAK, PID_STALL: pid_kind = PK_HSHAKE;
      default:                     pid_kind = PK_BAD;
    endcase
    if ((PID_CHECK != 0) && (rcv_data[7:4] != ~rcv_data[3:0])) begin
      pid_kind = PK_BAD;
    end
  end

  // Next-state and next-output logic; a received byte always wins over eop
  always_comb begin
    state_nxt  = state;
    error_nxt  = rx_error;
    packet_nxt = rx_packet;
    data_nxt   = rx_packet_data;
    count_nxt  = rx_byte_count;
    store_nxt  = 1'b0;
    flush_nxt  = 1'b0;
    cnt_inc    = rx_byte_count + CNT_W'(1);

    case (state)
      IDLE: begin
        if (d_edge) begin
          state_nxt = SYNC;
          count_nxt = '0;
          error_nxt = 1'b0;
        end
      end

      SYNC: begin
        if (byte_received) begin
          state_nxt = (rcv_data == SYNC_BYTE) ? PID : ERR;
        end else if (eop) begin
          state_nxt = ERR;
        end
      end

      PID: begin
        if (byte_received) begin
          case (pid_kind)
            PK_TOKEN: begin
              state_nxt  = TOKEN;
              packet_nxt = rcv_data[3:0];
            end
            PK_DATA: begin
              state_nxt  = DATA;
              packet_nxt = rcv_data[3:0];
              flush_nxt  = 1'b1;
            end
            PK_HSHAKE: begin
              state_nxt  = HSHAKE;
              packet_nxt = rcv_data[3:0];
            end
            default: state_nxt = ERR;
          endcase
        end else if (eop) begin
          state_nxt = ERR;
        end
      end

      TOKEN: begin
        if (byte_received) begin
          count_nxt = cnt_inc;
          data_nxt  = rcv_data;
          if (rx_byte_count == CNT_TWO) begin
            state_nxt = ERR;
          end
        end else if (eop) begin
          state_nxt = (rx_byte_count == CNT_TWO) ? DONE : ERR;
        end
      end

      DATA: begin
        if (byte_received) begin
          if (buffer_occupancy >= OCC_FULL) begin
            state_nxt = ERR;
          end else begin
            count_nxt = cnt_inc;
            if (cnt_inc == CNT_LIMIT) begin
              state_nxt = ERR;
            end else begin
              data_nxt  = rcv_data;
              store_nxt = 1'b1;
            end
          end
        end else if (eop) begin
          state_nxt = (rx_byte_count >= CNT_TWO) ? DONE : ERR;
        end
      end

      HSHAKE: begin
        if (byte_received) begin
          state_nxt = ERR;
        end else if (eop) begin
          state_nxt = DONE;
        end
      end

      ERR: begin
        if (eop) begin
          state_nxt = IDLE;
        end
      end

      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Error entry: flag sticks until the next packet start, FIFO is discarded
    if ((state_nxt == ERR) && (state != ERR)) begin
      error_nxt  = 1'b1;
      flush_nxt  = 1'b1;
      packet_nxt = 4'h0;
    end

    ready_nxt  = (state_nxt == DONE);
    active_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                <= IDLE;
      rx_transfer_active   <= 1'b0;
      rx_error             <= 1'b0;
      rx_packet            <= 4'h0;
      rx_data_ready        <= 1'b0;
      rx_packet_data       <= 8'h00;
      store_rx_packet_data <= 1'b0;
      flush                <= 1'b0;
      rx_byte_count        <= '0;
    end else begin
      state                <= state_nxt;
      rx_transfer_active   <= active_nxt;
      rx_error             <= error_nxt;
      rx_packet            <= packet_nxt;
      rx_data_ready        <= ready_nxt;
      rx_packet_data       <= data_nxt;
      store_rx_packet_data <= store_nxt;
      flush                <= flush_nxt;
      rx_byte_count        <= count_nxt;
    end
  end

endmodule
